// File: rtl/div_enable_pipe_pkg.sv
// Shared constants, types and helpers for the div_enable_pipe clock-enable divider.
package div_enable_pipe_pkg;

  localparam int unsigned TICK_CNT_W = 16;
  localparam int unsigned DIV_W_MAX  = 32;

  typedef logic [DIV_W_MAX-1:0] div_word_t;

  typedef struct packed {
    div_word_t cnt;
    div_word_t div;
  } div_pair_t;

  function automatic int unsigned fill_width(input int unsigned stages);
    return (stages < 2) ? 1 : $clog2(stages);
  endfunction

endpackage

// File: rtl/div_enable_gen.sv
// Programmable divide-by-(D+1) enable generator with glitch-free divisor reload.
module div_enable_gen
  import div_enable_pipe_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             wrap,
  output logic             div_busy,
  output logic             tick,
  output logic             clk_div_q
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] shadow;
  logic             pending;

  assign wrap     = (cnt == div_q);
  assign div_busy = pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      div_q     <= DIV_INIT;
      shadow    <= '0;
      pending   <= 1'b0;
      tick      <= 1'b0;
      clk_div_q <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      tick      <= 1'b1;
      clk_div_q <= ~clk_div_q;
      pending   <= 1'b0;
      // A load landing on the wrap edge wins over any older shadow value
      if (div_load) begin
        div_q <= div_value;
      end else if (pending) begin
        div_q <= shadow;
      end
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
      if (div_load) begin
        shadow  <= div_value;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_enable_pipe.sv
// Divided enable strobe plus strobe-advanced retiming pipeline, single clock domain.
// Optional tick_count output enabled by defining DIV_ENABLE_PIPE_TICK_CNT_EN.
module div_enable_pipe
  import div_enable_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [WIDTH-1:0] data_in,
  output logic             div_busy,
  output logic             tick,
  output logic             clk_div_q,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid
`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_count
`endif
);

  localparam int unsigned       FILL_W    = fill_width(STAGES);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(STAGES - 1);

  logic                          wrap;
  logic [STAGES-1:0][WIDTH-1:0]  stage_q;
  logic [FILL_W-1:0]             fill_q;

  div_enable_gen #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_gen (
    .clock     (clock),
    .reset     (reset),
    .div_load  (div_load),
    .div_value (div_value),
    .wrap      (wrap),
    .div_busy  (div_busy),
    .tick      (tick),
    .clk_div_q (clk_div_q)
  );

  // Later stages share the clock and advance only on the wrap enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_in;
      if (wrap) begin
        for (int unsigned i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  assign data_out = stage_q[STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_q    <= '0;
      out_valid <= 1'b0;
    end else if (wrap && (fill_q != FILL_LAST)) begin
      fill_q <= fill_q + 1'b1;
      if (fill_q == FILL_LAST - 1'b1) begin
        out_valid <= 1'b1;
      end
    end
  end

`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
    end else if (wrap && (tick_count != '1)) begin
      tick_count <= tick_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_div_enable_pipe.sv
// Directed bench for div_enable_pipe: vector table plus reset / pipeline corner sequences.
module tb_div_enable_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       div_load;
  logic [7:0] div_value;
  logic [7:0] data_in;

  logic       a_busy, a_tick, a_clk, a_valid;
  logic [7:0] a_dout;
  logic       b_busy, b_tick, b_clk, b_valid;
  logic [7:0] b_dout;
  logic       c_busy, c_tick, c_clk, c_valid;
  logic [7:0] c_dout;
`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
  logic [15:0] a_tcnt, b_tcnt, c_tcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_enable_pipe #(.WIDTH(8), .STAGES(2), .DIV_W(8), .DIV_RESET(0)) dut_a (
    .clock(clock), .reset(reset), .div_load(div_load), .div_value(div_value),
    .data_in(data_in), .div_busy(a_busy), .tick(a_tick), .clk_div_q(a_clk),
    .data_out(a_dout), .out_valid(a_valid)
`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
    , .tick_count(a_tcnt)
`endif
  );

  div_enable_pipe #(.WIDTH(8), .STAGES(3), .DIV_W(8), .DIV_RESET(1)) dut_b (
    .clock(clock), .reset(reset), .div_load(div_load), .div_value(div_value),
    .data_in(data_in), .div_busy(b_busy), .tick(b_tick), .clk_div_q(b_clk),
    .data_out(b_dout), .out_valid(b_valid)
`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
    , .tick_count(b_tcnt)
`endif
  );

  div_enable_pipe #(.WIDTH(8), .STAGES(2), .DIV_W(8), .DIV_RESET(5)) dut_c (
    .clock(clock), .reset(reset), .div_load(div_load), .div_value(div_value),
    .data_in(data_in), .div_busy(c_busy), .tick(c_tick), .clk_div_q(c_clk),
    .data_out(c_dout), .out_valid(c_valid)
`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
    , .tick_count(c_tcnt)
`endif
  );

  typedef struct {
    logic       ld;
    logic [7:0] val;
    logic       t;
    logic       c;
    logic       b;
    logic       v;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // data_in before edge n is 8'(n*17); data_out follows the value seen just before each wrap
    tbl[0]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
    tbl[8]  = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA};
    tbl[11] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCC};
    tbl[13] = '{1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCC};
    tbl[14] = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hEE};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEE};
    tbl[16] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEE};
    tbl[17] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21};
    tbl[18] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21};
    tbl[19] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21};
    tbl[20] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h54};

    reset     = 1'b1;
    div_load  = 1'b0;
    div_value = 8'd0;
    data_in   = 8'd0;
    repeat (3) step();
    check("reset_a", {a_busy, a_tick, a_clk, a_valid, a_dout}, 32'd0);
    check("reset_b", {b_busy, b_tick, b_clk, b_valid, b_dout}, 32'd0);
    check("reset_c", {c_busy, c_tick, c_clk, c_valid, c_dout}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      div_load  = tbl[i].ld;
      div_value = tbl[i].val;
      data_in   = 8'((i + 1) * 17);
      step();
      check($sformatf("e%0d_tick", i + 1), a_tick, tbl[i].t);
      check($sformatf("e%0d_clk_div_q", i + 1), a_clk, tbl[i].c);
      check($sformatf("e%0d_div_busy", i + 1), a_busy, tbl[i].b);
      check($sformatf("e%0d_out_valid", i + 1), a_valid, tbl[i].v);
      check($sformatf("e%0d_data_out", i + 1), a_dout, tbl[i].d);
    end
    div_load  = 1'b0;
    div_value = 8'd0;

    // Three-stage pipeline, D=1: value present before edges 2 and 3 emerges at edge 6
    reset = 1'b1;
    #2;
    reset   = 1'b0;
    data_in = 8'h00;
    step();
    data_in = 8'hA5;
    step();
    step();
    check("pipe_valid_e3", b_valid, 1'b0);
    data_in = 8'h00;
    step();
    check("pipe_valid_e4", b_valid, 1'b1);
    check("pipe_dout_e4", b_dout, 8'h00);
    step();
    check("pipe_dout_e5", b_dout, 8'h00);
    step();
    check("pipe_dout_e6", b_dout, 8'hA5);
    check("pipe_tick_e6", b_tick, 1'b1);
    step();
    step();
    check("pipe_dout_e8", b_dout, 8'h00);

    // Asynchronous reset mid-period with a pending load on the D=5 instance
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    div_load  = 1'b1;
    div_value = 8'd9;
    step();
    check("rst_busy_before", c_busy, 1'b1);
    div_load  = 1'b0;
    div_value = 8'd0;
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_c", {c_busy, c_tick, c_clk, c_valid, c_dout}, 32'd0);
    #2;
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("rst_tick_e%0d", e), c_tick, (e == 6) ? 1'b1 : 1'b0);
    end
    check("rst_clk_e6", c_clk, 1'b1);
    check("rst_busy_e6", c_busy, 1'b0);
    check("rst_valid_e6", c_valid, 1'b1);

`ifdef DIV_ENABLE_PIPE_TICK_CNT_EN
    reset = 1'b1;
    #2;
    check("tcnt_reset", a_tcnt, 16'h0000);
    reset = 1'b0;
    repeat (5) step();
    check("tcnt_5", a_tcnt, 16'd5);
    repeat (69995) step();
    check("tcnt_sat", a_tcnt, 16'hFFFF);
    repeat (10) step();
    check("tcnt_hold", a_tcnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_enable_pipe.md
# div_enable_pipe

Parametrised successor to the divide-by-two flop chain. It generates a programmable divide-by-(D+1) clock-enable strobe and a 50 % duty divided square wave. It also retimes a WIDTH-bit bus through a STAGES-deep pipeline: the first stage runs on every clock and later stages advance only on the strobe. Everything sits in the single `clock` domain, and no derived clock drives any flop, which removes the divided-clock race between stages.

## Interface
- WIDTH, 8, data bus width (≥1)
- STAGES, 2, total pipeline stages including the full-rate first stage (≥2)
- DIV_W, 8, divisor register width (≥1)
- DIV_RESET, 0, divisor value loaded at reset (< 2^DIV_W)
- Reset is asynchronous and active-high. The block has one clock, `clock`, and one reset, `reset`.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- div_load  in  1  request to load div_value
- div_value  in  DIV_W  new divisor D; tick period is D+1 cycles
- data_in  in  WIDTH  data sampled every cycle into stage 0
- div_busy  out  1  a loaded divisor is pending, not yet applied
- tick  out  1  one-cycle enable strobe, registered
- clk_div_q  out  1  toggles on every tick
- data_out  out  WIDTH  last pipeline stage
- out_valid  out  1  pipeline filled since reset

## Operation
- Registers: cnt[DIV_W], div_q[DIV_W], shadow[DIV_W], pending, fill counter (saturating at STAGES-1), stage[0..STAGES-1].
- A **wrap edge** is any rising edge with cnt == div_q.
  - On a wrap edge: cnt←0, tick←1, clk_div_q←~clk_div_q.
  - On any other edge: cnt←cnt+1, tick←0.
- D=0 gives tick high continuously and clk_div_q toggling every cycle, which is the legacy divide-by-2.
- Divisor update is glitch-free:
  - div_load on a non-wrap edge: shadow←div_value, pending←1.
  - On the next wrap edge: div_q←shadow, pending←0.
- div_load on a wrap edge: div_q←div_value immediately and pending←0. Any older pending shadow is discarded.
- A second div_load while pending overwrites shadow (last-writer-wins).
- div_busy is the pending register.
- Pipeline:
  - stage[0]←data_in on every edge.
  - On wrap edges only, stage[i]←stage[i-1] for i ≥ 1.
  - data_out is stage[STAGES-1].
- fill increments on each wrap edge and saturates at STAGES-1. out_valid←1 on the edge where fill reaches STAGES-1, and stays 1 until reset.
- cnt arithmetic is unsigned modulo 2^DIV_W. The compare uses equality only, so cnt never exceeds div_q.

## Timing
- Reset values: cnt=0, div_q=DIV_RESET, shadow=0, pending=0, tick=0, clk_div_q=0, all stages=0, fill=0, out_valid=0, div_busy=0.
- Edge 1 is the first rising edge after reset deasserts. The first wrap edge is edge D+1, and every following wrap edge comes D+1 edges later.
- tick, clk_div_q, data_out and out_valid all update on the same wrap edge.
- Latency from data_in to data_out:
  - data_in is captured into stage[0] at edge e.
  - It reaches data_out at the (STAGES-1)th wrap edge strictly after e.
- A new divisor D' takes effect at the next wrap edge. The period after that edge is D'+1.
- Reset asserted mid-period clears all state asynchronously. Any pending load is lost and counting restarts at edge 1.

## Configuration
- `DIV_ENABLE_PIPE_TICK_CNT_EN` defined:
  - Adds output `tick_count` (out, 16 bits), reset to 0.
  - It increments on every wrap edge and saturates at 16'hFFFF.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `div_enable_pipe_pkg` holds:
  - the tick_count width constant (16);
  - a typedef for the divisor/counter pair;
  - a function computing the fill width, $clog2(STAGES).
- One natural sub-module, `div_enable_gen`: cnt, div_q, shadow, pending, tick and clk_div_q. The top level instantiates it plus the pipeline and fill logic.

## Test plan
- DIV_RESET=0, reset released → tick=1 from edge 1; clk_div_q toggles every cycle (1,0,1,…); out_valid=1 at edge 1 with STAGES=2.
- div_value=3 loaded on a wrap edge → tick high at edges +4, +8, +12; clk_div_q period 8 cycles; div_busy stays 0.
- D=3, div_load with value 1 at cnt=1 → div_busy=1 until the next wrap edge; wrap edges then occur every 2 cycles.
- STAGES=3, D=1, data_in=8'hA5 at edge 2 then 8'h00 → data_out=8'hA5 at edge 6 (second wrap after capture); out_valid rises at edge 4.
- reset pulsed at cnt=2 with D=5 and pending=1 → all outputs at reset values immediately; after release the first tick is at edge 6 using div_q=DIV_RESET.
- With `DIV_ENABLE_PIPE_TICK_CNT_EN` and D=0 for 70000 cycles → tick_count=16'hFFFF and held.
